ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set, reset, typematic, etc.) from the FPGA to the keyboard using the PS/2 request-to-send protocol. It sits beside the PS/2 receive path on the same two open-drain lines. Its `busy` output lets receive logic ignore line activity while a host frame is in flight. The top level maps `*_oe` to tristate buffers on the shared inout pins.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `INHIBIT_US`, 100: clock-inhibit time before request-to-send.
- `START_TIMEOUT_US`, 15000: maximum time from clock release to the first device falling edge.
- `FRAME_TIMEOUT_US`, 2000: maximum time from the first falling edge to the ACK sample.

- `clk`  in  1: system clock; all flops are rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `tx_data`  in  8: byte to send.
- `tx_valid`  in  1: request; the byte is accepted when `tx_valid && tx_ready`.
- `tx_ready`  out  1: high only in IDLE.
- `ps2_clk_in`  in  1: raw PS/2 clock pin level.
- `ps2_data_in`  in  1: raw PS/2 data pin level.
- `ps2_clk_oe`  out  1: 1 drives the clock pin low; 0 releases it.
- `ps2_data_oe`  out  1: 1 drives the data pin low; 0 releases it.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the frame completes with ACK = 0.
- `err`  out  1: one-cycle pulse on a failed frame.
- `err_code`  out  2: valid with `err`. 01 = NACK, 10 = START_TIMEOUT, 11 = FRAME_TIMEOUT. Holds its last value otherwise.

## Operation
- Reset values: `tx_ready`=1. All other outputs are 0: `busy`, `done`, `err`, `err_code`, `ps2_clk_oe`, `ps2_data_oe`. State is IDLE, counters are 0.
- Inputs pass through a 2-flop synchronizer. A falling edge `fe` is the synchronized clock going 1→0 between consecutive cycles.
- On accept, latch `tx_data` and compute parity `p = ~^tx_data` (odd parity).
- States and transitions:
  - IDLE: on accept, go to INHIBIT.
  - INHIBIT: `clk_oe`=1 for INHIBIT_CYC = CLK_HZ/1e6*INHIBIT_US cycles, then go to RTS.
  - RTS: `clk_oe`=1 and `data_oe`=1 for exactly 16 cycles, then go to START.
  - START: `clk_oe`=0, `data_oe`=1 (this is the start bit). On `fe`, go to DATA with bit index 0.
  - DATA: on each `fe` the driven bit is applied in this order: fe#1→d0, fe#2..fe#8→d1..d7, fe#9→p. `data_oe` equals the inverse of the bit being sent.
  - STOP: fe#10 sets `data_oe`=0 (stop bit released).
  - ACK: on fe#11, sample synchronized data. 0 means ACK; 1 means NACK. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1. Then pulse `done` on ACK, or `err` with 01 on NACK, and return to IDLE.
- Timeouts:
  - START_TIMEOUT: START lasts longer than the start timeout. Release both lines, pulse `err` with 10, go to IDLE.
  - FRAME_TIMEOUT: more than the frame timeout passes from fe#1 to the ACK sample. Release both lines, pulse `err` with 11, go to IDLE.
- `tx_valid` while `busy` is ignored; no queueing.
- Reset asserted mid-frame releases both lines immediately (asynchronously) and discards the frame.
- Counter widths are sized with $clog2 of the largest cycle count.

## Timing
- An accept at cycle N gives `ps2_clk_oe`=1 and `tx_ready`=0 at N+1.
- The drive change follows a pin falling edge by exactly 3 cycles: 2 synchronizer cycles plus 1 registered-output cycle. This is well inside the 30 µs device clock-low half period.
- `done`/`err` are high for exactly one cycle. `tx_ready` returns to 1 in the same cycle as that pulse.
- A `tx_valid` accept is possible on the cycle after `done`.
- A rising edge on the device clock has no effect. Only falling edges advance the frame.

## Configuration
- `PS2_HOST_TX_TIMEOUT_EN`:
  - Defined: both timeouts are active and `err_code` can be 10 or 11.
  - Undefined: timeout counters are removed, START/ACK wait indefinitely, and only 01 can be reported.
- INHIBIT and RTS timing are unaffected by the macro.

## Structure
- Shared package `ps2_pkg`:
  - state enum: IDLE, INHIBIT, RTS, START, DATA, STOP, ACK, WAIT_IDLE;
  - `err_code` localparams ERR_NACK, ERR_START_TO, ERR_FRAME_TO;
  - function `us_to_cyc(clk_hz, us)`.
- Sub-module `ps2_line_sync`: 2-flop synchronizers for clock and data plus falling-edge detect on clock. The receive path reuses it.

## Test plan
Benches use CLK_HZ=1_000_000, so INHIBIT=100 cycles.
- Reset: assert `reset`=0 → all outputs at their reset values, and both `oe` are 0 even while `clk` is stopped.
- Send 0xED with a device model clocking at 12.5 kHz and returning ACK = 0:
  - `clk_oe` is high for 116 cycles, then data bits sample 1,0,1,1,0,1,1,1;
  - parity is 1 and stop is 1;
  - one `done` pulse, no `err`.
- Send 0x00:
  - all data bits are 0 and parity is 1;
  - the device returns ACK = 1 → `err`=1, `err_code`=01, no `done`.
- Device never clocks:
  - with the macro defined → `err_code`=10 exactly 15000 cycles after entering START, and both lines are released;
  - without the macro → the block is still in START after 20000 cycles.
- Device stops after fe#5 (macro defined) → `err_code`=11 and `busy` falls in the same cycle.
- Mid-frame and back-to-back:
  - drop `reset` at fe#4 → both `oe` are 0 at once; after release a new 0xF4 frame completes normally;
  - `tx_valid` held through the frame → a second frame starts on the cycle after `done`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, error codes and a cycle-count helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    START,
    DATA,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [1:0] ERR_NACK     = 2'b01;
  localparam logic [1:0] ERR_START_TO = 2'b10;
  localparam logic [1:0] ERR_FRAME_TO = 2'b11;

  localparam int unsigned RTS_CYC = 16;

  function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus clock falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fe
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Reset to the idle-high bus level so release from reset never looks like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fe    = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (request-to-send, odd parity, ACK check).
// Define PS2_HOST_TX_TIMEOUT_EN to enable the start and frame timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned INHIBIT_CYC  = us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam int unsigned START_TO_CYC = us_to_cyc(CLK_HZ, START_TIMEOUT_US);
  localparam int unsigned FRAME_TO_CYC = us_to_cyc(CLK_HZ, FRAME_TIMEOUT_US);
  localparam int unsigned MAX_A   = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
  localparam int unsigned MAX_B   = (START_TO_CYC > FRAME_TO_CYC) ? START_TO_CYC : FRAME_TO_CYC;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic clk_sync, data_sync, clk_fe;

  ps2_line_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fe     (clk_fe)
  );

  ps2_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       idx_q, idx_d;
  logic             nack_q, nack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      nack_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      nack_q     <= nack_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    nack_d     = nack_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d = {~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = RTS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RTS: begin
        if (cnt_q == CNT_W'(RTS_CYC - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START: begin
        // Counter restarts at fe#1 so it then measures the frame window.
        if (clk_fe) begin
          state_d = DATA;
          idx_d   = '0;
          cnt_d   = '0;
        end
`ifdef PS2_HOST_TX_TIMEOUT_EN
        else if (cnt_q == CNT_W'(START_TO_CYC - 1)) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_START_TO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DATA: begin
        if (clk_fe) begin
          if (idx_q == 4'd8) state_d = STOP;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      STOP: state_d = ACK;
      ACK: begin
        if (clk_fe) begin
          nack_d  = data_sync;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          state_d = IDLE;
          if (nack_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_NACK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
    if ((state_q inside {DATA, STOP, ACK}) && (state_d != WAIT_IDLE)) begin
      if (cnt_q == CNT_W'(FRAME_TO_CYC - 1)) begin
        state_d    = IDLE;
        err_d      = 1'b1;
        err_code_d = ERR_FRAME_TO;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif

    // Line drives are registered from the next state: one cycle after the decision.
    clk_oe_d = state_d inside {INHIBIT, RTS};
    case (state_d)
      RTS, START: data_oe_d = 1'b1;
      DATA:       data_oe_d = ~shift_d[idx_d];
      default:    data_oe_d = 1'b0;
    endcase
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 keyboard model clocking at 12.5 kHz.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int n_pass = 0;
  int n_tot = 0;
  int n_done = 0;
  int n_err = 0;
  logic [1:0] last_code = 2'b00;
  logic       busy_at_err = 1'b1;
  logic       ready_at_done = 1'b0;

  ps2_host_tx #(
    .CLK_HZ          (1_000_000),
    .INHIBIT_US      (100),
    .START_TIMEOUT_US(15000),
    .FRAME_TIMEOUT_US(2000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 if (clk_en) clk = ~clk;

  always @(posedge clk) begin
    if (done) begin
      n_done        <= n_done + 1;
      ready_at_done <= tx_ready;
    end
    if (err) begin
      n_err       <= n_err + 1;
      last_code   <= err_code;
      busy_at_err <= busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Waits for the host start bit, then clocks n_fe falling edges; bits = {stop, p, d7..d0}.
  task automatic dev_frame(input int n_fe, input logic ack_bit, output logic [9:0] bits);
    int g;
    bits = '0;
    g = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && g < 1000) begin
      tick(1);
      g++;
    end
    check("dev_start_seen", 32'(g < 1000), 32'd1);
    tick(40);
    for (int k = 1; k <= n_fe; k++) begin
      if (k == 11) begin
        dev_data = ack_bit;
        tick(5);
      end
      dev_clk = 1'b0;
      tick(40);
      dev_clk = 1'b1;
      if (k <= 10) bits = {ps2_data_in, bits[9:1]};
      tick(40);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 2000) begin
      tick(1);
      g++;
    end
    check(tag, 32'(g < 2000), 32'd1);
    tick(2);
  endtask

  initial begin
    logic [9:0] bits;
    int cnt, d0, e0;

    // Reset with the clock stopped.
    #20;
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    clk_en = 1'b1;
    #23;
    reset = 1'b1;
    tick(3);

    // 0xED with ACK.
    d0 = n_done;
    e0 = n_err;
    send(8'hED);
    check("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("accept_not_ready", 32'(tx_ready), 32'd0);
    cnt = 0;
    while (ps2_clk_oe === 1'b1 && cnt < 1000) begin
      cnt++;
      tick(1);
    end
    check("clk_oe_high_cycles", 32'(cnt), 32'd116);
    dev_frame(11, 1'b0, bits);
    wait_idle("ed_end");
    check("ed_data", 32'(bits[7:0]), 32'hED);
    check("ed_parity", 32'(bits[8]), 32'd1);
    check("ed_stop", 32'(bits[9]), 32'd1);
    check("ed_done_pulses", 32'(n_done - d0), 32'd1);
    check("ed_no_err", 32'(n_err - e0), 32'd0);
    check("ed_ready_at_done", 32'(ready_at_done), 32'd1);

    // 0x00 with NACK.
    d0 = n_done;
    e0 = n_err;
    send(8'h00);
    dev_frame(11, 1'b1, bits);
    wait_idle("nack_end");
    check("nack_data", 32'(bits[7:0]), 32'h00);
    check("nack_parity", 32'(bits[8]), 32'd1);
    check("nack_err_pulses", 32'(n_err - e0), 32'd1);
    check("nack_code", 32'(last_code), 32'd1);
    check("nack_no_done", 32'(n_done - d0), 32'd0);

    // Device never clocks.
    send(8'h00);
    cnt = 0;
    while (ps2_clk_oe !== 1'b0 && cnt < 500) begin
      tick(1);
      cnt++;
    end
    check("start_entry_data_oe", 32'(ps2_data_oe), 32'd1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    cnt = 0;
    while (err !== 1'b1 && cnt < 16000) begin
      tick(1);
      cnt++;
    end
    check("start_to_cycles", 32'(cnt), 32'd15000);
    check("start_to_code", 32'(err_code), 32'd2);
    check("start_to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("start_to_data_oe", 32'(ps2_data_oe), 32'd0);
    tick(2);

    // Device stops after fe#5.
    e0 = n_err;
    send(8'h00);
    dev_frame(5, 1'b0, bits);
    cnt = 0;
    while (n_err == e0 && cnt < 3000) begin
      tick(1);
      cnt++;
    end
    check("frame_to_seen", 32'(n_err - e0), 32'd1);
    check("frame_to_code", 32'(last_code), 32'd3);
    check("frame_to_busy_low", 32'(busy_at_err), 32'd0);
    check("frame_to_data_oe", 32'(ps2_data_oe), 32'd0);
`else
    e0 = n_err;
    tick(20000);
    check("no_to_busy", 32'(busy), 32'd1);
    check("no_to_start_clk", 32'(ps2_clk_oe), 32'd0);
    check("no_to_start_data", 32'(ps2_data_oe), 32'd1);
    check("no_to_no_err", 32'(n_err - e0), 32'd0);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
`endif

    // Reset dropped at fe#4 with the clock stopped.
    send(8'h00);
    dev_frame(4, 1'b0, bits);
    check("mid_data_oe_before", 32'(ps2_data_oe), 32'd1);
    clk_en = 1'b0;
    #3;
    reset = 1'b0;
    #2;
    check("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    clk_en = 1'b1;
    #20;
    reset = 1'b1;
    tick(3);

    // 0xF4 after the aborted frame.
    d0 = n_done;
    e0 = n_err;
    send(8'hF4);
    dev_frame(11, 1'b0, bits);
    wait_idle("f4_end");
    check("f4_data", 32'(bits[7:0]), 32'hF4);
    check("f4_parity", 32'(bits[8]), 32'd0);
    check("f4_done_pulses", 32'(n_done - d0), 32'd1);
    check("f4_no_err", 32'(n_err - e0), 32'd0);

    // tx_valid held: the next frame starts the cycle after done.
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    tick(1);
    dev_frame(11, 1'b0, bits);
    cnt = 0;
    while (done !== 1'b1 && cnt < 500) begin
      tick(1);
      cnt++;
    end
    check("b2b_done_seen", 32'(done), 32'd1);
    check("b2b_ready_with_done", 32'(tx_ready), 32'd1);
    tick(1);
    check("b2b_restart_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("b2b_restart_busy", 32'(busy), 32'd1);
    tx_valid = 1'b0;
    check("b2b_data", 32'(bits[7:0]), 32'hED);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
